// File: rtl/btb_upd_pkg.sv
// Shared op codes, queue entry layouts and op decode for the BTB update arbiter.
package btb_upd_pkg;

  localparam int BTBU_PC_W  = 32;
  localparam int BTBU_IDX_W = 5;
  localparam int BTBU_OP_W  = 3;
  localparam int BTBU_TGT_W = 32;

  typedef enum logic [BTBU_OP_W-1:0] {
    BTBU_ADD      = 3'd0,
    BTBU_DEL      = 3'd1,
    BTBU_PRE_R    = 3'd2,
    BTBU_PRE_E    = 3'd3,
    BTBU_TGT_E    = 3'd4,
    BTBU_RAS_PUSH = 3'd5,
    BTBU_RAS_POP  = 3'd6,
    BTBU_RAS_ADD  = 3'd7
  } btbu_op_e;

  typedef struct packed {
    btbu_op_e              op;
    logic [BTBU_PC_W-1:0]  pc;
    logic [BTBU_IDX_W-1:0] index;
  } id_entry_t;

  typedef struct packed {
    btbu_op_e              op;
    logic [BTBU_PC_W-1:0]  pc;
    logic [BTBU_IDX_W-1:0] index;
    logic                  orien;
    logic [BTBU_TGT_W-1:0] target;
  } ex_entry_t;

  typedef struct packed {
    logic pop_ras;
    logic push_ras;
    logic add_entry;
    logic delete_entry;
    logic pre_error;
    logic pre_right;
    logic target_error;
  } btbu_flags_t;

  typedef struct packed {
    logic                  en;
    logic [BTBU_PC_W-1:0]  pc;
    logic [BTBU_IDX_W-1:0] index;
    btbu_flags_t           flags;
    logic                  orien;
    logic [BTBU_TGT_W-1:0] target;
  } btbu_out_t;

  function automatic btbu_flags_t btbu_decode(input btbu_op_e op);
    btbu_flags_t f;
    f = '0;
    case (op)
      BTBU_ADD:      f.add_entry    = 1'b1;
      BTBU_DEL:      f.delete_entry = 1'b1;
      BTBU_PRE_R:    f.pre_right    = 1'b1;
      BTBU_PRE_E:    f.pre_error    = 1'b1;
      BTBU_TGT_E:    f.target_error = 1'b1;
      BTBU_RAS_PUSH: f.push_ras     = 1'b1;
      BTBU_RAS_POP:  f.pop_ras      = 1'b1;
      BTBU_RAS_ADD: begin
        f.pop_ras   = 1'b1;
        f.add_entry = 1'b1;
      end
      default: f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// In-order synchronous queue with a flush that empties it and drops a same-cycle push.
module btb_upd_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  always_comb begin
    push_ok  = push && !flush && (count_q != CW'(DEPTH));
    pop_ok   = pop && !flush && (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk) mem_q <= mem_d;

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/btb_update_arbiter.sv
// Arbitrates ID and EX predictor-training queues onto the single BTB operate port.
// Optional BTB_UPD_STAT_EN adds wrapping 32-bit issue/starvation/flush counters.
module btb_update_arbiter
  import btb_upd_pkg::*;
#(
  parameter int QDEPTH     = 4,
  parameter int STARVE_LIM = 8,
  parameter int IDXW       = BTBU_IDX_W
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [2:0]      id_op,
  input  logic [31:0]     id_pc,
  input  logic [IDXW-1:0] id_index,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [2:0]      ex_op,
  input  logic [31:0]     ex_pc,
  input  logic [IDXW-1:0] ex_index,
  input  logic            ex_orien,
  input  logic [31:0]     ex_target,
  output logic            operate_en,
  output logic [31:0]     operate_pc,
  output logic [IDXW-1:0] operate_index,
  output logic            pop_ras,
  output logic            push_ras,
  output logic            add_entry,
  output logic            delete_entry,
  output logic            pre_error,
  output logic            pre_right,
  output logic            target_error,
  output logic            right_orien,
  output logic [31:0]     right_target
`ifdef BTB_UPD_STAT_EN
  ,
  output logic [31:0]     stat_ex_issue,
  output logic [31:0]     stat_id_issue,
  output logic [31:0]     stat_starve_win,
  output logic [31:0]     stat_id_flushed
`endif
);
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIM + 1);

  id_entry_t     id_in, id_head;
  ex_entry_t     ex_in, ex_head;
  logic [CW-1:0] id_count, ex_count;
  logic          id_elig, ex_ne, id_win, ex_win, starve_hit;
  logic [SW-1:0] starve_q, starve_d;
  btbu_out_t     out_q, out_d;

  assign id_ready = (id_count != CW'(QDEPTH));
  assign ex_ready = (ex_count != CW'(QDEPTH));
  assign id_in    = '{op: btbu_op_e'(id_op), pc: id_pc, index: id_index};
  assign ex_in    = '{op: btbu_op_e'(ex_op), pc: ex_pc, index: ex_index,
                      orien: ex_orien, target: ex_target};

  btb_upd_fifo #(.W($bits(id_entry_t)), .DEPTH(QDEPTH), .CW(CW)) u_id_q (
    .clk(clk), .resetn(resetn), .flush(flush),
    .push(id_valid && id_ready), .pop(id_win), .din(id_in),
    .dout(id_head), .count(id_count)
  );

  btb_upd_fifo #(.W($bits(ex_entry_t)), .DEPTH(QDEPTH), .CW(CW)) u_ex_q (
    .clk(clk), .resetn(resetn), .flush(1'b0),
    .push(ex_valid && ex_ready), .pop(ex_win), .din(ex_in),
    .dout(ex_head), .count(ex_count)
  );

  always_comb begin
    // A flushed ID queue is treated as empty for this cycle's arbitration.
    id_elig    = (id_count != '0) && !flush;
    ex_ne      = (ex_count != '0);
    starve_hit = id_elig && (starve_q == SW'(STARVE_LIM));
    id_win     = 1'b0;
    ex_win     = 1'b0;
    if (starve_hit)   id_win = 1'b1;
    else if (ex_ne)   ex_win = 1'b1;
    else if (id_elig) id_win = 1'b1;

    if (!id_elig || id_win)              starve_d = '0;
    else if (starve_q != SW'(STARVE_LIM)) starve_d = starve_q + SW'(1);
    else                                  starve_d = starve_q;

    out_d = '0;
    if (ex_win) begin
      out_d.en     = 1'b1;
      out_d.pc     = ex_head.pc;
      out_d.index  = ex_head.index;
      out_d.flags  = btbu_decode(ex_head.op);
      out_d.orien  = ex_head.orien;
      out_d.target = ex_head.target;
    end else if (id_win) begin
      out_d.en    = 1'b1;
      out_d.pc    = id_head.pc;
      out_d.index = id_head.index;
      out_d.flags = btbu_decode(id_head.op);
      out_d.orien = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      starve_q <= '0;
      out_q    <= '0;
    end else begin
      starve_q <= starve_d;
      out_q    <= out_d;
    end
  end

  assign operate_en    = out_q.en;
  assign operate_pc    = out_q.pc;
  assign operate_index = out_q.index;
  assign pop_ras       = out_q.flags.pop_ras;
  assign push_ras      = out_q.flags.push_ras;
  assign add_entry     = out_q.flags.add_entry;
  assign delete_entry  = out_q.flags.delete_entry;
  assign pre_error     = out_q.flags.pre_error;
  assign pre_right     = out_q.flags.pre_right;
  assign target_error  = out_q.flags.target_error;
  assign right_orien   = out_q.orien;
  assign right_target  = out_q.target;

`ifdef BTB_UPD_STAT_EN
  logic [31:0] st_ex_q, st_ex_d, st_id_q, st_id_d, st_sw_q, st_sw_d, st_fl_q, st_fl_d;

  always_comb begin
    st_ex_d = st_ex_q + 32'(ex_win);
    st_id_d = st_id_q + 32'(id_win);
    st_sw_d = st_sw_q + 32'(starve_hit);
    st_fl_d = st_fl_q + (flush ? 32'(id_count) : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      st_ex_q <= '0;
      st_id_q <= '0;
      st_sw_q <= '0;
      st_fl_q <= '0;
    end else begin
      st_ex_q <= st_ex_d;
      st_id_q <= st_id_d;
      st_sw_q <= st_sw_d;
      st_fl_q <= st_fl_d;
    end
  end

  assign stat_ex_issue   = st_ex_q;
  assign stat_id_issue   = st_id_q;
  assign stat_starve_win = st_sw_q;
  assign stat_id_flushed = st_fl_q;
`endif

endmodule

// File: tb/tb_btb_update_arbiter.sv
// Scoreboard bench: a queue-based reference model predicts each cycle's BTB update.
module tb_btb_update_arbiter;
  localparam int QD  = 4;
  localparam int LIM = 8;

  logic        clk, resetn, flush;
  logic        id_valid, id_ready, ex_valid, ex_ready, ex_orien;
  logic [2:0]  id_op, ex_op;
  logic [31:0] id_pc, ex_pc, ex_target;
  logic [4:0]  id_index, ex_index;
  logic        operate_en, pop_ras, push_ras, add_entry, delete_entry;
  logic        pre_error, pre_right, target_error, right_orien;
  logic [31:0] operate_pc, right_target;
  logic [4:0]  operate_index;

  btb_update_arbiter #(.QDEPTH(QD), .STARVE_LIM(LIM), .IDXW(5)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_op(id_op), .id_pc(id_pc),
    .id_index(id_index),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_pc(ex_pc),
    .ex_index(ex_index), .ex_orien(ex_orien), .ex_target(ex_target),
    .operate_en(operate_en), .operate_pc(operate_pc), .operate_index(operate_index),
    .pop_ras(pop_ras), .push_ras(push_ras), .add_entry(add_entry),
    .delete_entry(delete_entry), .pre_error(pre_error), .pre_right(pre_right),
    .target_error(target_error), .right_orien(right_orien), .right_target(right_target)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] pc;
    logic [4:0]  idx;
    logic        orien;
    logic [31:0] target;
  } req_t;

  typedef struct {
    logic [77:0] port;
    logic [1:0]  rdy;
  } exp_t;

  req_t idq[$];
  req_t exq[$];
  exp_t expq[$];
  int   starve;
  int   checks = 0;
  int   failures = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {pop, push, add, del, pre_e, pre_r, tgt_e}
  function automatic logic [6:0] op_flags(input logic [2:0] op);
    case (op)
      3'd0:    return 7'b001_0000;
      3'd1:    return 7'b000_1000;
      3'd2:    return 7'b000_0010;
      3'd3:    return 7'b000_0100;
      3'd4:    return 7'b000_0001;
      3'd5:    return 7'b010_0000;
      3'd6:    return 7'b100_0000;
      default: return 7'b101_0000;
    endcase
  endfunction

  task automatic model_step();
    exp_t e;
    req_t r;
    bit   id_has, ex_has, take_id, take_ex, id_acc, ex_acc;
    e.port = '0;
    if (!resetn) begin
      idq.delete();
      exq.delete();
      starve = 0;
    end else begin
      id_has  = (idq.size() > 0) && !flush;
      ex_has  = exq.size() > 0;
      take_id = 0;
      take_ex = 0;
      if (id_has && starve == LIM) take_id = 1;
      else if (ex_has)             take_ex = 1;
      else if (id_has)             take_id = 1;
      id_acc = idq.size() < QD;
      ex_acc = exq.size() < QD;
      if (take_ex) begin
        r = exq.pop_front();
        e.port = {1'b1, r.pc, r.idx, op_flags(r.op), r.orien, r.target};
      end else if (take_id) begin
        r = idq.pop_front();
        e.port = {1'b1, r.pc, r.idx, op_flags(r.op), 1'b1, 32'd0};
      end
      if (!id_has || take_id) starve = 0;
      else if (starve < LIM)  starve = starve + 1;
      if (flush) idq.delete();
      else if (id_valid && id_acc)
        idq.push_back('{op: id_op, pc: id_pc, idx: id_index, orien: 1'b1, target: 32'd0});
      if (ex_valid && ex_acc)
        exq.push_back('{op: ex_op, pc: ex_pc, idx: ex_index, orien: ex_orien, target: ex_target});
    end
    e.rdy = {idq.size() < QD, exq.size() < QD};
    expq.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    exp_t        e;
    logic [77:0] act;
    @(negedge clk);
    act = {operate_en, operate_pc, operate_index, pop_ras, push_ras, add_entry,
           delete_entry, pre_error, pre_right, target_error, right_orien, right_target};
    checks++;
    if (expq.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty t=%0t actual=%h required=expectation", $time, act);
    end else begin
      e = expq.pop_front();
      if (act !== e.port) begin
        failures++;
        $display("FAIL operate t=%0t actual=%h required=%h", $time, act, e.port);
      end
      checks++;
      if ({id_ready, ex_ready} !== e.rdy) begin
        failures++;
        $display("FAIL ready t=%0t actual=%b required=%b", $time, {id_ready, ex_ready}, e.rdy);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_in();
    id_valid = 0; ex_valid = 0; flush = 0;
  endtask

  task automatic rand_ex();
    ex_op     = 3'($urandom_range(0, 4));
    ex_pc     = $urandom;
    ex_index  = 5'($urandom);
    ex_orien  = 1'($urandom);
    ex_target = $urandom;
  endtask

  task automatic set_id(input logic [2:0] op, input logic [31:0] pc, input logic [4:0] idx);
    id_valid = 1; id_op = op; id_pc = pc; id_index = idx;
  endtask

  initial begin
    bit acc;
    resetn = 0; flush = 0; id_valid = 0; ex_valid = 0;
    id_op = 0; id_pc = 0; id_index = 0;
    ex_op = 0; ex_pc = 0; ex_index = 0; ex_orien = 0; ex_target = 0;
    tick(2);
    resetn = 1;
    tick(2);

    // EX only: ADD
    ex_valid = 1; ex_op = 3'd0; ex_pc = 32'h1c00_0100; ex_target = 32'h1c00_0200;
    ex_index = 5'd3; ex_orien = 1;
    tick();
    clear_in();
    tick(3);

    // Simultaneous ID RAS_PUSH and EX PRE_R
    set_id(3'd5, 32'h0000_0100, 5'd1);
    ex_valid = 1; ex_op = 3'd2; ex_pc = 32'h0000_0200; ex_index = 5'd2;
    tick();
    clear_in();
    tick(3);

    // Starvation: one ID entry against a continuous EX stream
    set_id(3'd6, 32'h0000_0300, 5'd7);
    ex_valid = 1; rand_ex();
    tick();
    id_valid = 0;
    for (int i = 0; i < 16; i++) begin
      rand_ex();
      tick();
    end
    clear_in();
    tick(8);

    // Fill ID while EX keeps the port busy; five ID requests held until accepted
    ex_valid = 1;
    for (int k = 0; k < 5; k++) begin
      set_id(3'd7, 32'(4 * k), 5'(k));
      for (int w = 0; w < 60; w++) begin
        rand_ex();
        acc = id_ready;
        tick();
        if (acc) break;
      end
    end
    clear_in();
    tick(20);

    // Flush with ID and EX queued; ID enqueue in the flush cycle is dropped
    ex_valid = 1;
    for (int k = 0; k < 3; k++) begin
      set_id(3'd0, 32'h0000_1000 + 32'(k), 5'(k));
      rand_ex();
      tick();
    end
    ex_valid = 0;
    set_id(3'd1, 32'h0000_2000, 5'd9);
    flush = 1;
    tick();
    clear_in();
    tick(8);

    // Reset mid-burst
    for (int k = 0; k < 5; k++) begin
      set_id(3'($urandom), $urandom, 5'($urandom));
      ex_valid = 1; rand_ex();
      tick();
    end
    clear_in();
    resetn = 0;
    tick();
    resetn = 1;
    tick(3);

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      id_valid = 1'($urandom);
      id_op    = 3'($urandom);
      id_pc    = $urandom;
      id_index = 5'($urandom);
      ex_valid = ($urandom_range(0, 3) != 0);
      rand_ex();
      flush    = ($urandom_range(0, 19) == 0);
      resetn   = ($urandom_range(0, 149) != 0);
      tick();
    end
    clear_in();
    resetn = 1;
    tick(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
